axi_irq_ctrl: RTL and testbench
===============================

Name: axi_irq_ctrl

Overview:
- AXI4 slave interrupt controller between the SoC peripherals (UART rx, Ethernet rx/tx, mtimer, SPI, GPIO) and the core's external-interrupt input.
- Synchronises raw sources, latches edge/level pending state, masks it per source, and drives one registered request line to the core.
- Software reads CLAIM to get the lowest-numbered active source and, for edge sources, acknowledge it.

Parameters:
- N_SOURCES, 8, number of interrupt sources (1..31).
- SYNC_STAGES, 2, flop stages on each source input (>=2).
- ID_WIDTH, 8, AXI ID width echoed on R/B channels.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-low reset
- axi_mosi  in  s_axi_mosi_t  AXI4 slave request channels
- axi_miso  out  s_axi_miso_t  AXI4 slave response channels
- irq_src_i  in  N_SOURCES  raw interrupt sources, asynchronous, active-high
- irq_o  out  1  interrupt request to core, registered

Behaviour:
- Register map (decode addr[4:2], word-aligned, upper bits ignored):
  - 0x00 PENDING: RW1C for edge sources.
  - 0x04 ENABLE: RW.
  - 0x08 TRIGGER: RW, 1=edge, 0=level.
  - 0x0C CLAIM: RO, side-effecting.
  - 0x10 INFO: RO, returns N_SOURCES.
  - Other offsets read 0, writes ignored, resp OKAY. Bits >= N_SOURCES read 0.
- Reset (rst=0): PENDING=0, ENABLE=0, TRIGGER=0, sync flops=0, irq_o=0, all valid/ready outputs=0, rresp/bresp=OKAY.
- Sources: SYNC_STAGES-flop sync, then prev-value flop for edge detection.
  - Edge source: rising edge sets PENDING[i].
  - Level source: PENDING[i] follows the synced level each cycle; W1C and claim have no effect.
- Set/clear collision: a rising edge wins over W1C or claim-clear on the same bit in the same cycle, so the bit stays 1.
- irq_o: registered |(PENDING & ENABLE). It rises 1 cycle after PENDING changes. Raw-input to irq_o latency for an enabled edge source is SYNC_STAGES+2 cycles.
- CLAIM read:
  - Returns id+1 of the lowest-index bit in PENDING&ENABLE, or 0 if none.
  - Value is sampled in the AR-accept cycle.
  - In that cycle, clears PENDING[id] if the source is edge-triggered.
- Read FSM: R_IDLE -> R_DATA.
  - R_IDLE: arready=1. On arvalid, latch araddr/arid/arlen and go to R_DATA.
  - R_DATA: rvalid=1 with rdata from the latched address, rid=arid, rresp=OKAY. Hold all outputs while rready=0.
  - Each rready beat decrements the beat counter. rlast=1 on beat arlen. After the last beat, return to R_IDLE (arready=1 next cycle).
  - Burst beats re-read the same register. A CLAIM side effect applies only once, at AR accept.
  - rvalid is 1 the cycle after AR accept; throughput is 1 read per arlen+2 cycles.
- Write FSM: W_IDLE -> W_DATA -> W_RESP.
  - W_IDLE: awready=1. Latch awaddr/awid.
  - W_DATA: wready=1. Each accepted beat applies to the latched register with wstrb byte masking; state updates the next cycle.
  - On wlast go to W_RESP: bvalid=1, bid=awid, bresp=OKAY, held until bready, then W_IDLE.
  - wvalid arriving in W_IDLE is not accepted (wready=0).
- Read and write FSMs are independent. A simultaneous CLAIM-clear and W1C on different bits both take effect.
- ENABLE does not affect PENDING latching. A source enabled later with PENDING=1 asserts irq_o 1 cycle after the ENABLE write lands.
- Reset mid-transaction: both FSMs return to idle immediately, in-flight responses are dropped, and all registers are cleared.

Test Plan:
- Reset: rst=0 with arbitrary inputs -> irq_o=0, arvalid then returns ENABLE=0, PENDING=0, INFO=N_SOURCES(8).
- Edge: TRIGGER=0xFF, ENABLE=0x04, pulse irq_src_i[2] 1 cycle -> PENDING=0x04, irq_o=1 after SYNC_STAGES+2 cycles; CLAIM read=3; PENDING=0, irq_o=0 next cycle; second CLAIM=0.
- Level/priority: TRIGGER=0, ENABLE=0xFF, hold src[5] and src[1] high -> CLAIM=2 repeatedly, W1C 0xFF has no effect; drop src[1] -> CLAIM=6; drop src[5] -> irq_o=0 within SYNC_STAGES+2 cycles.
- Collision: edge mode, PENDING[3]=1, W1C 0x08 landing in the same cycle as a new rising edge on src[3] -> PENDING[3] remains 1, irq_o stays 1.
- Backpressure/burst: arlen=3 on CLAIM with rready toggling 1/0 and src[0] pending -> 4 beats all 1, rlast only on 4th, rid echoed, PENDING[0] cleared once; write with bready=0 for 5 cycles -> bvalid held, awready=0 until bready.
- Reset mid-op: assert rst while in R_DATA with rvalid=1 and rready=0 -> rvalid=0 immediately, arready=1 after release, registers zero.

Source files
------------

// File: rtl/axi_irq_ctrl.sv
// axi_irq_ctrl: AXI4 slave interrupt controller.
// Synchronises raw peripheral interrupt sources, latches edge or level
// pending state, masks it per source and drives one registered request
// line to the core. Software reads CLAIM to get the lowest-numbered active
// source. For edge sources the same read also acknowledges that source.
//
// Ports:
//   clk        system clock
//   rst        asynchronous active-low reset
//   axi_mosi   AXI4 slave request channels (AW, W, B ready, AR, R ready)
//   axi_miso   AXI4 slave response channels
//   irq_src_i  raw interrupt sources, asynchronous, active-high
//   irq_o      interrupt request to the core, registered
//
// Register map (addr[4:2]): 0 PENDING (W1C for edge sources), 1 ENABLE,
// 2 TRIGGER (1 = edge), 3 CLAIM (RO, side-effecting), 4 INFO (N_SOURCES).

package axi_irq_pkg;
  localparam int AXI_ADDR_W = 32;
  localparam int AXI_DATA_W = 32;
  localparam int AXI_ID_W   = 8;

  typedef struct packed {
    logic [AXI_ADDR_W-1:0]   awaddr;
    logic [AXI_ID_W-1:0]     awid;
    logic                    awvalid;
    logic [AXI_DATA_W-1:0]   wdata;
    logic [AXI_DATA_W/8-1:0] wstrb;
    logic                    wlast;
    logic                    wvalid;
    logic                    bready;
    logic [AXI_ADDR_W-1:0]   araddr;
    logic [AXI_ID_W-1:0]     arid;
    logic [7:0]              arlen;
    logic                    arvalid;
    logic                    rready;
  } s_axi_mosi_t;

  typedef struct packed {
    logic                  awready;
    logic                  wready;
    logic [AXI_ID_W-1:0]   bid;
    logic [1:0]            bresp;
    logic                  bvalid;
    logic                  arready;
    logic [AXI_DATA_W-1:0] rdata;
    logic [AXI_ID_W-1:0]   rid;
    logic [1:0]            rresp;
    logic                  rlast;
    logic                  rvalid;
  } s_axi_miso_t;
endpackage

module axi_irq_ctrl
  import axi_irq_pkg::*;
#(
  parameter int N_SOURCES   = 8,
  parameter int SYNC_STAGES = 2,
  parameter int ID_WIDTH    = AXI_ID_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  s_axi_mosi_t          axi_mosi,
  output s_axi_miso_t          axi_miso,
  input  logic [N_SOURCES-1:0] irq_src_i,
  output logic                 irq_o
);

  typedef enum logic {R_IDLE, R_DATA} r_state_e;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;

  localparam logic [2:0] ADDR_PENDING = 3'd0;
  localparam logic [2:0] ADDR_ENABLE  = 3'd1;
  localparam logic [2:0] ADDR_TRIGGER = 3'd2;
  localparam logic [2:0] ADDR_CLAIM   = 3'd3;
  localparam logic [2:0] ADDR_INFO    = 3'd4;

  logic [N_SOURCES-1:0] sync_q [SYNC_STAGES];
  logic [N_SOURCES-1:0] prev_q, src_sync, src_rise;
  logic [N_SOURCES-1:0] pending_q, pending_d, enable_q, enable_d, trigger_q, trigger_d;
  logic [N_SOURCES-1:0] active, claim_onehot, claim_clr, w1c;
  logic                 claim_hit, irq_q;
  logic [4:0]           claim_id;
  logic [31:0]          claim_value, wmask, wbits;

  r_state_e             r_state_q, r_state_d;
  logic [2:0]           r_addr_q, r_addr_d;
  logic [ID_WIDTH-1:0]  r_id_q, r_id_d;
  logic [7:0]           r_len_q, r_len_d, r_cnt_q, r_cnt_d;
  logic [31:0]          rdata_q, rdata_d;
  logic                 arready_q, arready_d, rvalid_q, rvalid_d, rlast_q, rlast_d;

  w_state_e             w_state_q, w_state_d;
  logic [2:0]           w_addr_q, w_addr_d;
  logic [ID_WIDTH-1:0]  w_id_q, w_id_d;
  logic                 wr_en;
  logic                 awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;

  function automatic logic [31:0] ext(input logic [N_SOURCES-1:0] v);
    logic [31:0] r;
    r = '0;
    r[N_SOURCES-1:0] = v;
    return r;
  endfunction

  function automatic logic [31:0] reg_read(input logic [2:0] sel);
    case (sel)
      ADDR_PENDING: return ext(pending_q);
      ADDR_ENABLE:  return ext(enable_q);
      ADDR_TRIGGER: return ext(trigger_q);
      ADDR_CLAIM:   return claim_value;
      ADDR_INFO:    return 32'(N_SOURCES);
      default:      return '0;
    endcase
  endfunction

  assign src_sync = sync_q[SYNC_STAGES-1];
  assign src_rise = src_sync & ~prev_q;
  assign active   = pending_q & enable_q;

  // Lowest-index active source wins; scanning downwards lets the last hit stand.
  always_comb begin
    claim_hit    = 1'b0;
    claim_id     = '0;
    claim_onehot = '0;
    for (int i = N_SOURCES - 1; i >= 0; i--) begin
      if (active[i]) begin
        claim_hit = 1'b1;
        claim_id  = 5'(i);
      end
    end
    for (int i = 0; i < N_SOURCES; i++) begin
      claim_onehot[i] = claim_hit && (claim_id == 5'(i));
    end
    claim_value = claim_hit ? ({27'b0, claim_id} + 32'd1) : '0;
  end

  // Read channel: a CLAIM side effect happens only at AR accept; burst beats
  // of CLAIM repeat the value sampled there, other registers are re-read.
  always_comb begin
    r_state_d = r_state_q;
    r_addr_d  = r_addr_q;
    r_id_d    = r_id_q;
    r_len_d   = r_len_q;
    r_cnt_d   = r_cnt_q;
    rdata_d   = rdata_q;
    claim_clr = '0;
    case (r_state_q)
      R_IDLE: begin
        if (arready_q && axi_mosi.arvalid) begin
          r_state_d = R_DATA;
          r_addr_d  = axi_mosi.araddr[4:2];
          r_id_d    = axi_mosi.arid;
          r_len_d   = axi_mosi.arlen;
          r_cnt_d   = '0;
          rdata_d   = reg_read(axi_mosi.araddr[4:2]);
          if (axi_mosi.araddr[4:2] == ADDR_CLAIM) begin
            claim_clr = claim_onehot & trigger_q;
          end
        end
      end
      R_DATA: begin
        if (rvalid_q && axi_mosi.rready) begin
          if (r_cnt_q == r_len_q) begin
            r_state_d = R_IDLE;
          end else begin
            r_cnt_d = r_cnt_q + 8'd1;
            if (r_addr_q != ADDR_CLAIM) begin
              rdata_d = reg_read(r_addr_q);
            end
          end
        end
      end
      default: r_state_d = R_IDLE;
    endcase
    arready_d = (r_state_d == R_IDLE);
    rvalid_d  = (r_state_d == R_DATA);
    rlast_d   = (r_state_d == R_DATA) && (r_cnt_d == r_len_d);
  end

  // Write channel: address phase, any number of data beats, then response.
  always_comb begin
    w_state_d = w_state_q;
    w_addr_d  = w_addr_q;
    w_id_d    = w_id_q;
    wr_en     = 1'b0;
    case (w_state_q)
      W_IDLE: begin
        if (awready_q && axi_mosi.awvalid) begin
          w_state_d = W_DATA;
          w_addr_d  = axi_mosi.awaddr[4:2];
          w_id_d    = axi_mosi.awid;
        end
      end
      W_DATA: begin
        if (wready_q && axi_mosi.wvalid) begin
          wr_en = 1'b1;
          if (axi_mosi.wlast) begin
            w_state_d = W_RESP;
          end
        end
      end
      W_RESP: begin
        if (bvalid_q && axi_mosi.bready) begin
          w_state_d = W_IDLE;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
    awready_d = (w_state_d == W_IDLE);
    wready_d  = (w_state_d == W_DATA);
    bvalid_d  = (w_state_d == W_RESP);
  end

  // Register updates. A rising edge overrides any clear on the same bit;
  // level sources simply mirror the synchronised input.
  always_comb begin
    for (int b = 0; b < 4; b++) begin
      wmask[8*b +: 8] = {8{axi_mosi.wstrb[b]}};
    end
    wbits     = axi_mosi.wdata & wmask;
    enable_d  = enable_q;
    trigger_d = trigger_q;
    w1c       = '0;
    if (wr_en) begin
      case (w_addr_q)
        ADDR_PENDING: w1c = wbits[N_SOURCES-1:0];
        ADDR_ENABLE:  enable_d  = (enable_q & ~wmask[N_SOURCES-1:0]) | wbits[N_SOURCES-1:0];
        ADDR_TRIGGER: trigger_d = (trigger_q & ~wmask[N_SOURCES-1:0]) | wbits[N_SOURCES-1:0];
        default: ;
      endcase
    end
    pending_d = (trigger_q & ((pending_q & ~w1c & ~claim_clr) | src_rise)) |
                (~trigger_q & src_sync);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      prev_q    <= '0;
      pending_q <= '0;
      enable_q  <= '0;
      trigger_q <= '0;
      irq_q     <= 1'b0;
      r_state_q <= R_IDLE;
      r_addr_q  <= '0;
      r_id_q    <= '0;
      r_len_q   <= '0;
      r_cnt_q   <= '0;
      rdata_q   <= '0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      w_state_q <= W_IDLE;
      w_addr_q  <= '0;
      w_id_q    <= '0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
    end else begin
      sync_q[0] <= irq_src_i;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      prev_q    <= src_sync;
      pending_q <= pending_d;
      enable_q  <= enable_d;
      trigger_q <= trigger_d;
      irq_q     <= |active;
      r_state_q <= r_state_d;
      r_addr_q  <= r_addr_d;
      r_id_q    <= r_id_d;
      r_len_q   <= r_len_d;
      r_cnt_q   <= r_cnt_d;
      rdata_q   <= rdata_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rlast_q   <= rlast_d;
      w_state_q <= w_state_d;
      w_addr_q  <= w_addr_d;
      w_id_q    <= w_id_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
    end
  end

  assign irq_o            = irq_q;
  assign axi_miso.awready = awready_q;
  assign axi_miso.wready  = wready_q;
  assign axi_miso.bid     = w_id_q;
  assign axi_miso.bresp   = 2'b00;
  assign axi_miso.bvalid  = bvalid_q;
  assign axi_miso.arready = arready_q;
  assign axi_miso.rdata   = rdata_q;
  assign axi_miso.rid     = r_id_q;
  assign axi_miso.rresp   = 2'b00;
  assign axi_miso.rlast   = rlast_q;
  assign axi_miso.rvalid  = rvalid_q;

  logic unused_bits;
  assign unused_bits = ^{axi_mosi.araddr[31:5], axi_mosi.araddr[1:0],
                         axi_mosi.awaddr[31:5], axi_mosi.awaddr[1:0],
                         wbits[31:N_SOURCES], wmask[31:N_SOURCES]};

endmodule

// File: tb/tb_axi_irq_ctrl.sv
// tb_axi_irq_ctrl: self-checking bench for axi_irq_ctrl (8 sources, 2 sync stages).
// Table-driven register vectors, hand-written multi-cycle sequences and a
// randomized pass checked against a rule-level model of PENDING/CLAIM.
module tb_axi_irq_ctrl;
  import axi_irq_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  s_axi_mosi_t mosi;
  s_axi_miso_t miso;
  logic [7:0]  src;
  logic        irq;
  int          total = 0;
  int          bad = 0;

  typedef struct {
    logic        doWrite;
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] raddr;
    logic [31:0] expData;
  } vec_t;

  vec_t vecs[13];

  always #5 clk = ~clk;

  axi_irq_ctrl #(.N_SOURCES(8), .SYNC_STAGES(2), .ID_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .axi_mosi(mosi), .axi_miso(miso),
    .irq_src_i(src), .irq_o(irq)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic timeoutFail(input string name);
    total++;
    bad++;
    $display("[TB] FAIL %s: handshake timeout", name);
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic readReg(input logic [31:0] addr, output logic [31:0] data);
    int n;
    @(negedge clk);
    mosi.araddr = addr; mosi.arid = 8'h11; mosi.arlen = 8'd0;
    mosi.arvalid = 1'b1; mosi.rready = 1'b1;
    n = 0;
    while (!miso.arready && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) timeoutFail("read_ar");
    @(negedge clk);
    mosi.arvalid = 1'b0;
    n = 0;
    while (!miso.rvalid && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) timeoutFail("read_r");
    data = miso.rdata;
    @(negedge clk);
    mosi.rready = 1'b0;
  endtask

  task automatic writeReg(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
    int n;
    @(negedge clk);
    mosi.awaddr = addr; mosi.awid = 8'h22; mosi.awvalid = 1'b1;
    n = 0;
    while (!miso.awready && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) timeoutFail("write_aw");
    @(negedge clk);
    mosi.awvalid = 1'b0;
    mosi.wdata = data; mosi.wstrb = strb; mosi.wlast = 1'b1; mosi.wvalid = 1'b1;
    n = 0;
    while (!miso.wready && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) timeoutFail("write_w");
    @(negedge clk);
    mosi.wvalid = 1'b0; mosi.wlast = 1'b0; mosi.bready = 1'b1;
    n = 0;
    while (!miso.bvalid && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) timeoutFail("write_b");
    @(negedge clk);
    mosi.bready = 1'b0;
  endtask

  task automatic applyStimulus(input int idx);
    logic [31:0] rd;
    if (vecs[idx].doWrite) writeReg(vecs[idx].waddr, vecs[idx].wdata, vecs[idx].wstrb);
    readReg(vecs[idx].raddr, rd);
    checkOutput($sformatf("vec%0d", idx), rd, vecs[idx].expData);
  endtask

  initial begin
    logic [31:0] rd;
    logic [7:0]  trig, en, p, q, expPend, act;
    int          expClaim, n, beats;
    logic        rr;

    rst = 1'b0;
    mosi = '0;
    src = '0;

    // Reset with garbage on every input
    waitCycles(2);
    mosi = s_axi_mosi_t'({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom});
    src = 8'($urandom);
    waitCycles(4);
    checkOutput("rst_irq", {31'b0, irq}, 32'd0);
    checkOutput("rst_arready", {31'b0, miso.arready}, 32'd0);
    checkOutput("rst_rvalid", {31'b0, miso.rvalid}, 32'd0);
    checkOutput("rst_awready", {31'b0, miso.awready}, 32'd0);
    checkOutput("rst_bvalid", {31'b0, miso.bvalid}, 32'd0);
    mosi = '0;
    src = '0;
    rst = 1'b1;
    @(negedge clk);
    checkOutput("rst_arready_after", {31'b0, miso.arready}, 32'd1);
    readReg(32'h04, rd); checkOutput("rst_enable", rd, 32'h0);
    readReg(32'h00, rd); checkOutput("rst_pending", rd, 32'h0);
    readReg(32'h08, rd); checkOutput("rst_trigger", rd, 32'h0);
    readReg(32'h10, rd); checkOutput("rst_info", rd, 32'd8);

    // Register map / byte strobe vectors
    vecs[0]  = '{1'b1, 32'h04,  32'hFFFFFFFF, 4'hF, 32'h04, 32'hFF};
    vecs[1]  = '{1'b1, 32'h04,  32'h12345678, 4'h1, 32'h04, 32'h78};
    vecs[2]  = '{1'b1, 32'h04,  32'h000000AA, 4'h2, 32'h04, 32'h78};
    vecs[3]  = '{1'b1, 32'h04,  32'h000000A5, 4'h1, 32'h04, 32'hA5};
    vecs[4]  = '{1'b1, 32'h08,  32'h0000003C, 4'hF, 32'h08, 32'h3C};
    vecs[5]  = '{1'b1, 32'h14,  32'hFFFFFFFF, 4'hF, 32'h14, 32'h00};
    vecs[6]  = '{1'b0, 32'h00,  32'h0,        4'h0, 32'h10, 32'h08};
    vecs[7]  = '{1'b1, 32'h10,  32'h000000FF, 4'hF, 32'h10, 32'h08};
    vecs[8]  = '{1'b0, 32'h00,  32'h0,        4'h0, 32'h24, 32'hA5};
    vecs[9]  = '{1'b1, 32'h104, 32'h0000000F, 4'hF, 32'h04, 32'h0F};
    vecs[10] = '{1'b1, 32'h00,  32'hFFFFFFFF, 4'hF, 32'h00, 32'h00};
    vecs[11] = '{1'b0, 32'h00,  32'h0,        4'h0, 32'h0C, 32'h00};
    vecs[12] = '{1'b1, 32'h1C,  32'h000000FF, 4'hF, 32'h1C, 32'h00};
    for (int i = 0; i < 13; i++) applyStimulus(i);
    writeReg(32'h08, 32'h0, 4'hF);
    writeReg(32'h04, 32'h0, 4'hF);

    // Edge source: one-cycle pulse on src[2], latency and claim
    writeReg(32'h08, 32'hFF, 4'hF);
    writeReg(32'h04, 32'h04, 4'hF);
    @(negedge clk); src[2] = 1'b1;
    @(negedge clk); src[2] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("edge_irq_early", {31'b0, irq}, 32'd0);
    @(negedge clk);
    checkOutput("edge_irq_latency", {31'b0, irq}, 32'd1);
    readReg(32'h00, rd); checkOutput("edge_pending", rd, 32'h04);
    readReg(32'h0C, rd); checkOutput("edge_claim", rd, 32'd3);
    checkOutput("edge_irq_after_claim", {31'b0, irq}, 32'd0);
    readReg(32'h00, rd); checkOutput("edge_pending_cleared", rd, 32'h0);
    readReg(32'h0C, rd); checkOutput("edge_claim2", rd, 32'd0);

    // Level sources and priority
    writeReg(32'h08, 32'h0, 4'hF);
    writeReg(32'h04, 32'hFF, 4'hF);
    @(negedge clk); src = 8'h22;
    waitCycles(6);
    readReg(32'h0C, rd); checkOutput("lvl_claim_a", rd, 32'd2);
    readReg(32'h0C, rd); checkOutput("lvl_claim_b", rd, 32'd2);
    writeReg(32'h00, 32'hFF, 4'hF);
    readReg(32'h00, rd); checkOutput("lvl_pending_w1c", rd, 32'h22);
    readReg(32'h0C, rd); checkOutput("lvl_claim_c", rd, 32'd2);
    @(negedge clk); src = 8'h20;
    waitCycles(6);
    readReg(32'h0C, rd); checkOutput("lvl_claim_6", rd, 32'd6);
    checkOutput("lvl_irq_high", {31'b0, irq}, 32'd1);
    @(negedge clk); src = 8'h00;
    waitCycles(4);
    checkOutput("lvl_irq_drop", {31'b0, irq}, 32'd0);

    // Collision: W1C lands on the same edge that a new rise sets the bit
    writeReg(32'h08, 32'hFF, 4'hF);
    writeReg(32'h04, 32'h08, 4'hF);
    writeReg(32'h00, 32'hFF, 4'hF);
    @(negedge clk); src[3] = 1'b1;
    @(negedge clk); src[3] = 1'b0;
    waitCycles(6);
    checkOutput("coll_pre_irq", {31'b0, irq}, 32'd1);
    @(negedge clk);
    mosi.awaddr = 32'h00; mosi.awid = 8'h33; mosi.awvalid = 1'b1;
    n = 0;
    while (!miso.awready && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) timeoutFail("coll_aw");
    @(negedge clk);
    mosi.awvalid = 1'b0;
    src[3] = 1'b1;
    mosi.wdata = 32'h08; mosi.wstrb = 4'hF; mosi.wlast = 1'b1;
    @(negedge clk);
    @(negedge clk);
    mosi.wvalid = 1'b1;
    @(negedge clk);
    mosi.wvalid = 1'b0; mosi.wlast = 1'b0; mosi.bready = 1'b1;
    n = 0;
    while (!miso.bvalid && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) timeoutFail("coll_b");
    @(negedge clk);
    mosi.bready = 1'b0;
    src[3] = 1'b0;
    checkOutput("coll_irq", {31'b0, irq}, 32'd1);
    readReg(32'h00, rd); checkOutput("coll_pending", rd, 32'h08);
    writeReg(32'h00, 32'h08, 4'hF);
    readReg(32'h00, rd); checkOutput("coll_w1c_later", rd, 32'h0);
    checkOutput("coll_irq_cleared", {31'b0, irq}, 32'd0);

    // CLAIM burst with rready backpressure
    writeReg(32'h04, 32'h01, 4'hF);
    @(negedge clk); src[0] = 1'b1;
    @(negedge clk); src[0] = 1'b0;
    waitCycles(6);
    readReg(32'h00, rd); checkOutput("burst_pending_pre", rd, 32'h01);
    @(negedge clk);
    mosi.araddr = 32'h0C; mosi.arid = 8'h5A; mosi.arlen = 8'd3;
    mosi.arvalid = 1'b1; mosi.rready = 1'b0;
    n = 0;
    while (!miso.arready && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) timeoutFail("burst_ar");
    @(negedge clk);
    mosi.arvalid = 1'b0;
    beats = 0;
    rr = 1'b1;
    for (int c = 0; c < 40 && beats < 4; c++) begin
      mosi.rready = rr;
      if (miso.rvalid && rr) begin
        checkOutput($sformatf("burst_data%0d", beats), miso.rdata, 32'd1);
        checkOutput($sformatf("burst_rid%0d", beats), {24'b0, miso.rid}, 32'h5A);
        checkOutput($sformatf("burst_rlast%0d", beats), {31'b0, miso.rlast}, {31'b0, beats == 3});
        beats++;
      end else if (!rr) begin
        checkOutput($sformatf("burst_hold%0d", c), {31'b0, miso.rvalid}, 32'd1);
      end
      rr = !rr;
      @(negedge clk);
    end
    mosi.rready = 1'b0;
    checkOutput("burst_beats", beats, 32'd4);
    checkOutput("burst_arready", {31'b0, miso.arready}, 32'd1);
    readReg(32'h00, rd); checkOutput("burst_pending_post", rd, 32'h0);

    // Write response backpressure
    @(negedge clk);
    mosi.awaddr = 32'h04; mosi.awid = 8'h3C; mosi.awvalid = 1'b1;
    n = 0;
    while (!miso.awready && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) timeoutFail("bp_aw");
    @(negedge clk);
    mosi.awvalid = 1'b0;
    mosi.wdata = 32'h81; mosi.wstrb = 4'hF; mosi.wlast = 1'b1; mosi.wvalid = 1'b1;
    n = 0;
    while (!miso.wready && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) timeoutFail("bp_w");
    @(negedge clk);
    mosi.wvalid = 1'b0; mosi.wlast = 1'b0; mosi.bready = 1'b0;
    checkOutput("bp_bid", {24'b0, miso.bid}, 32'h3C);
    for (int c = 0; c < 5; c++) begin
      checkOutput($sformatf("bp_bvalid%0d", c), {31'b0, miso.bvalid}, 32'd1);
      checkOutput($sformatf("bp_awready%0d", c), {31'b0, miso.awready}, 32'd0);
      @(negedge clk);
    end
    mosi.bready = 1'b1;
    @(negedge clk);
    mosi.bready = 1'b0;
    checkOutput("bp_bvalid_done", {31'b0, miso.bvalid}, 32'd0);
    checkOutput("bp_awready_done", {31'b0, miso.awready}, 32'd1);
    readReg(32'h04, rd); checkOutput("bp_enable", rd, 32'h81);

    // Randomized configuration and source patterns against a rule model
    src = '0;
    waitCycles(6);
    for (int it = 0; it < 16; it++) begin
      trig = 8'($urandom_range(0, 255));
      en   = 8'($urandom_range(0, 255));
      p    = 8'($urandom_range(0, 255));
      q    = 8'($urandom_range(0, 255));
      writeReg(32'h00, 32'hFF, 4'hF);
      writeReg(32'h08, {24'b0, trig}, 4'hF);
      writeReg(32'h04, {24'b0, en}, 4'hF);
      @(negedge clk); src = p;
      waitCycles(6);
      @(negedge clk); src = p & q;
      waitCycles(6);
      // edge bits latched the 0->1 of p; level bits mirror what is still held
      expPend = (trig & p) | (~trig & p & q);
      checkOutput($sformatf("rnd%0d_irq", it), {31'b0, irq}, {31'b0, |(expPend & en)});
      readReg(32'h00, rd); checkOutput($sformatf("rnd%0d_pend", it), rd, {24'b0, expPend});
      act = expPend & en;
      expClaim = 0;
      for (int i = 7; i >= 0; i--) if (act[i]) expClaim = i + 1;
      if (expClaim != 0 && trig[expClaim-1]) expPend[expClaim-1] = 1'b0;
      readReg(32'h0C, rd); checkOutput($sformatf("rnd%0d_claim", it), rd, 32'(expClaim));
      readReg(32'h00, rd); checkOutput($sformatf("rnd%0d_pend2", it), rd, {24'b0, expPend});
      waitCycles(2);
      checkOutput($sformatf("rnd%0d_irq2", it), {31'b0, irq}, {31'b0, |(expPend & en)});
      src = '0;
      waitCycles(6);
    end

    // Reset in the middle of a read data phase
    writeReg(32'h04, 32'hFF, 4'hF);
    writeReg(32'h08, 32'h0F, 4'hF);
    @(negedge clk);
    mosi.araddr = 32'h10; mosi.arlen = 8'd0; mosi.arvalid = 1'b1; mosi.rready = 1'b0;
    n = 0;
    while (!miso.arready && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) timeoutFail("mid_ar");
    @(negedge clk);
    mosi.arvalid = 1'b0;
    checkOutput("mid_rvalid_pre", {31'b0, miso.rvalid}, 32'd1);
    #1 rst = 1'b0;
    #1;
    checkOutput("mid_rvalid", {31'b0, miso.rvalid}, 32'd0);
    checkOutput("mid_arready", {31'b0, miso.arready}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("mid_arready_after", {31'b0, miso.arready}, 32'd1);
    readReg(32'h04, rd); checkOutput("mid_enable", rd, 32'h0);
    readReg(32'h08, rd); checkOutput("mid_trigger", rd, 32'h0);
    readReg(32'h00, rd); checkOutput("mid_pending", rd, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
